// File: rtl/riscv_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master) and memory (slave).
interface riscv_fetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/riscv_fetch_buffer.sv
// Sequential prefetch queue feeding the single-cycle core; flushes and refetches on PC discontinuity.
// Optional FETCH_STATS_EN enables the stall/redirect counters (tied to zero otherwise).
module riscv_fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 pc_in,
  output logic [31:0]                 instr_out,
  output logic                        instr_valid,
  riscv_fetch_buffer_if.master        mem,
  output logic [15:0]                 stall_count,
  output logic [15:0]                 redirect_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned DW = 8;

  logic [31:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] discard;
  logic [31:0]   fetch_addr;
  logic          req_q;
  logic [31:0]   addr_q;

  logic          q_empty;
  logic [31:0]   head_addr;
  logic [31:0]   head_data;
  logic [31:0]   inflight_addr;
  logic [31:0]   expect_addr;
  logic          hit;
  logic          redirect;
  logic          gnt_acc;
  logic          drop;
  logic          push;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] out_nxt;
  logic [DW-1:0] discard_nxt;
  logic [31:0]   fetch_nxt;
  logic          req_nxt;

  // Live requests are always a contiguous run ending just below fetch_addr.
  always_comb begin
    q_empty       = (count == '0);
    head_addr     = q_addr[rd_ptr];
    head_data     = q_data[rd_ptr];
    inflight_addr = fetch_addr - (32'(outstanding) << 2);
    expect_addr   = fetch_addr;
    if (!q_empty)                expect_addr = head_addr;
    else if (outstanding != '0)  expect_addr = inflight_addr;
    hit       = !rst && !q_empty && (pc_in == head_addr);
    redirect  = !rst && (pc_in != expect_addr);
    gnt_acc   = req_q && mem.mem_gnt;
    drop      = mem.mem_rvalid && (redirect || (discard != '0));
    push      = mem.mem_rvalid && !drop;

    count_nxt   = count;
    out_nxt     = outstanding;
    discard_nxt = discard;
    fetch_nxt   = fetch_addr;
    req_nxt     = 1'b0;
    if (redirect) begin
      // Everything still in flight (plus this cycle's grant) becomes discard; a response now is one of them.
      count_nxt   = '0;
      out_nxt     = '0;
      discard_nxt = discard + DW'(outstanding) + DW'(gnt_acc) - DW'(mem.mem_rvalid);
      fetch_nxt   = pc_in;
    end else begin
      count_nxt   = count + CW'(push) - CW'(hit);
      out_nxt     = outstanding + CW'(gnt_acc) - CW'(push);
      discard_nxt = discard - DW'(drop);
      fetch_nxt   = gnt_acc ? fetch_addr + 32'd4 : fetch_addr;
      req_nxt     = (SW'(count_nxt) + SW'(out_nxt)) < SW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_addr  <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      count       <= count_nxt;
      outstanding <= out_nxt;
      discard     <= discard_nxt;
      fetch_addr  <= fetch_nxt;
      req_q       <= req_nxt;
      addr_q      <= fetch_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (hit)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_addr[wr_ptr] <= inflight_addr;
      q_data[wr_ptr] <= mem.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CW'(DEPTH))))
        else $error("fetch buffer: push into full queue");
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign instr_valid  = hit;
  assign instr_out    = hit ? head_data : NOP;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (!hit && (stall_count != 16'hFFFF))         stall_count    <= stall_count + 16'd1;
      if (redirect && (redirect_count != 16'hFFFF))  redirect_count <= redirect_count + 16'd1;
    end
  end
`else
  assign stall_count    = 16'h0000;
  assign redirect_count = 16'h0000;
`endif

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Directed bench for riscv_fetch_buffer with an in-order, 1-cycle-latency memory model.
module tb_riscv_fetch_buffer;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [15:0] stall_count;
  logic [15:0] redirect_count;
  logic        gnt_en;
  logic        rsp_en;
  int          gnt_count;
  logic [31:0] pend [$];
  int          n_cmp;
  int          n_bad;

  riscv_fetch_buffer_if bus();

  riscv_fetch_buffer #(.DEPTH(4), .NOP(NOP_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .mem            (bus),
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_gnt = gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] st_exp(input logic [15:0] v);
    return STATS ? 32'(v) : 32'h0;
  endfunction

  // Grants queue the address; the response follows at the next edge when enabled.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
      gnt_count      <= 0;
    end else begin
      if (bus.mem_req && bus.mem_gnt) begin
        pend.push_back(bus.mem_addr);
        gnt_count <= gnt_count + 1;
      end
      if (rsp_en && pend.size() != 0) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= mem_word(pend.pop_front());
      end else begin
        bus.mem_rvalid <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with rst low).
  task automatic reset_dut(input logic [31:0] pc, input logic g, input logic r);
    rst    = 1'b1;
    pc_in  = pc;
    gnt_en = g;
    rsp_en = r;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    pc_in  = '0;
    gnt_en = 1'b0;
    rsp_en = 1'b0;

    // Streaming from reset
    reset_dut(32'h0, 1'b1, 1'b1);
    check_eq("t1_c0_valid", 32'(instr_valid), 32'd0);
    check_eq("t1_c0_instr", instr_out, NOP_W);
    check_eq("t1_c0_req", 32'(bus.mem_req), 32'd0);
    check_eq("t1_c0_stall", 32'(stall_count), 32'd0);
    next_cycle();
    check_eq("t1_c1_req", 32'(bus.mem_req), 32'd1);
    check_eq("t1_c1_addr", bus.mem_addr, 32'h0);
    next_cycle();
    check_eq("t1_c2_addr", bus.mem_addr, 32'h4);
    check_eq("t1_c2_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t1_c3_addr", bus.mem_addr, 32'h8);
    check_eq("t1_c3_valid", 32'(instr_valid), 32'd1);
    check_eq("t1_c3_instr", instr_out, mem_word(32'h0));
    check_eq("t1_c3_stall", 32'(stall_count), st_exp(16'd3));
    next_cycle(); pc_in = 32'h4; #1;
    check_eq("t1_c4_instr", instr_out, mem_word(32'h4));
    check_eq("t1_c4_addr", bus.mem_addr, 32'hC);
    next_cycle(); pc_in = 32'h8; #1;
    check_eq("t1_c5_valid", 32'(instr_valid), 32'd1);
    check_eq("t1_c5_instr", instr_out, mem_word(32'h8));
    check_eq("t1_c5_redir", 32'(redirect_count), 32'd0);

    // Fill: responses held back, pc parked at 0
    reset_dut(32'h0, 1'b1, 1'b0);
    repeat (5) next_cycle();
    check_eq("t2_c5_req", 32'(bus.mem_req), 32'd0);
    check_eq("t2_c5_gnts", 32'(gnt_count), 32'd4);
    check_eq("t2_c5_valid", 32'(instr_valid), 32'd0);
    repeat (3) next_cycle();
    check_eq("t2_c8_req", 32'(bus.mem_req), 32'd0);
    check_eq("t2_c8_gnts", 32'(gnt_count), 32'd4);
    next_cycle(); rsp_en = 1'b1;
    next_cycle();
    check_eq("t2_c10_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t2_c11_instr", instr_out, mem_word(32'h0));
    check_eq("t2_c11_req", 32'(bus.mem_req), 32'd0);
    check_eq("t2_c11_stall", 32'(stall_count), st_exp(16'd11));
    next_cycle(); pc_in = 32'h4; #1;
    check_eq("t2_c12_instr", instr_out, mem_word(32'h4));
    check_eq("t2_c12_req", 32'(bus.mem_req), 32'd1);
    check_eq("t2_c12_addr", bus.mem_addr, 32'h10);
    check_eq("t2_c12_redir", 32'(redirect_count), 32'd0);

    // Redirect 0x8 -> 0x40 with two requests outstanding
    reset_dut(32'h0, 1'b1, 1'b1);
    repeat (3) next_cycle();
    check_eq("t3_c3_instr", instr_out, mem_word(32'h0));
    next_cycle(); pc_in = 32'h4; rsp_en = 1'b0; #1;
    next_cycle(); pc_in = 32'h8; #1;
    check_eq("t3_c5_instr", instr_out, mem_word(32'h8));
    next_cycle(); pc_in = 32'h40; gnt_en = 1'b0; #1;
    check_eq("t3_c6_valid", 32'(instr_valid), 32'd0);
    check_eq("t3_c6_instr", instr_out, NOP_W);
    next_cycle(); gnt_en = 1'b1; rsp_en = 1'b1; #1;
    check_eq("t3_c7_req", 32'(bus.mem_req), 32'd0);
    check_eq("t3_c7_redir", 32'(redirect_count), st_exp(16'd1));
    next_cycle();
    check_eq("t3_c8_req", 32'(bus.mem_req), 32'd1);
    check_eq("t3_c8_addr", bus.mem_addr, 32'h40);
    check_eq("t3_c8_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t3_c9_addr", bus.mem_addr, 32'h44);
    check_eq("t3_c9_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t3_c10_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t3_c11_valid", 32'(instr_valid), 32'd1);
    check_eq("t3_c11_instr", instr_out, mem_word(32'h40));
    check_eq("t3_c11_stall", 32'(stall_count), st_exp(16'd8));
    check_eq("t3_c11_redir", 32'(redirect_count), st_exp(16'd1));

    // Response arriving in the redirect cycle is dropped
    reset_dut(32'h0, 1'b1, 1'b1);
    repeat (2) next_cycle();
    pc_in = 32'h80; #1;
    check_eq("t4_c2_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t4_c3_req", 32'(bus.mem_req), 32'd0);
    check_eq("t4_c3_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t4_c4_addr", bus.mem_addr, 32'h80);
    next_cycle();
    check_eq("t4_c5_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    check_eq("t4_c6_instr", instr_out, mem_word(32'h80));
    check_eq("t4_c6_redir", 32'(redirect_count), st_exp(16'd1));
    check_eq("t4_c6_stall", 32'(stall_count), st_exp(16'd6));

    // Address wrap at the top of memory
    reset_dut(32'hFFFF_FFFC, 1'b1, 1'b1);
    check_eq("t5_c0_instr", instr_out, NOP_W);
    next_cycle();
    check_eq("t5_c1_req", 32'(bus.mem_req), 32'd0);
    next_cycle();
    check_eq("t5_c2_addr", bus.mem_addr, 32'hFFFF_FFFC);
    next_cycle();
    check_eq("t5_c3_req", 32'(bus.mem_req), 32'd1);
    check_eq("t5_c3_addr", bus.mem_addr, 32'h0);
    next_cycle();
    check_eq("t5_c4_instr", instr_out, mem_word(32'hFFFF_FFFC));
    check_eq("t5_c4_redir", 32'(redirect_count), st_exp(16'd1));
    next_cycle(); pc_in = 32'h0; #1;
    check_eq("t5_c5_instr", instr_out, mem_word(32'h0));

    // Reset masks a would-be hit and clears the counters
    next_cycle(); pc_in = 32'h4; rst = 1'b1; #1;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr_out, NOP_W);
    next_cycle();
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_stall", 32'(stall_count), 32'd0);
    check_eq("rst_redir", 32'(redirect_count), 32'd0);

    // No grants for 10 cycles
    reset_dut(32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      check_eq($sformatf("t6_c%0d_req", i), 32'(bus.mem_req), 32'd1);
      check_eq($sformatf("t6_c%0d_addr", i), bus.mem_addr, 32'h0);
      check_eq($sformatf("t6_c%0d_instr", i), instr_out, NOP_W);
    end
    check_eq("t6_stall", 32'(stall_count), st_exp(16'd10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
